// File: rtl/ring_sequencer_n.sv
// Parametrised one-hot ring / Johnson shift sequencer with run-time mode, direction,
// hold, parallel load and single-edge correction of illegal states back to HOME.
module ring_sequencer_n #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
  input  logic             MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] O,
  output logic             WRAP,
  output logic             FAULT
);

  // Edge priority | effect
  // RST           | O = HOME, flags cleared
  // LOAD          | O = LOAD_VAL verbatim, flags cleared
  // illegal O     | O = HOME, FAULT pulse
  // EN            | O = next(MODE, DIR), WRAP pulse on reaching HOME
  // otherwise     | hold, flags cleared

  logic [WIDTH-1:0] homeVal;
  logic [WIDTH-1:0] ringNext;
  logic [WIDTH-1:0] johnsonNext;
  logic [WIDTH-1:0] advanceVal;
  logic [WIDTH-1:0] nextO;
  logic [WIDTH-2:0] diffBits;
  logic             ringLegal;
  logic             johnsonLegal;
  logic             stateLegal;
  logic             nextWrap;
  logic             nextFault;

  function automatic logic atMostOne(input logic [WIDTH-1:0] v);
    return (v & (v - WIDTH'(1))) == '0;
  endfunction

  always_comb begin
    homeVal = MODE ? '0 : WIDTH'(1);
  end

  // A Johnson pattern has at most one boundary between its run of ones and zeros.
  always_comb begin
    diffBits     = O[WIDTH-2:0] ^ O[WIDTH-1:1];
    ringLegal    = (O != '0) && atMostOne(O);
    johnsonLegal = atMostOne({1'b0, diffBits});
    stateLegal   = MODE ? johnsonLegal : ringLegal;
  end

  always_comb begin
    ringNext    = DIR ? {O[0], O[WIDTH-1:1]}  : {O[WIDTH-2:0], O[WIDTH-1]};
    johnsonNext = DIR ? {~O[0], O[WIDTH-1:1]} : {O[WIDTH-2:0], ~O[WIDTH-1]};
    advanceVal  = MODE ? johnsonNext : ringNext;
  end

  always_comb begin
    nextO     = O;
    nextWrap  = 1'b0;
    nextFault = 1'b0;
    if (LOAD) begin
      nextO = LOAD_VAL;
    end else if (!stateLegal) begin
      nextO     = homeVal;
      nextFault = 1'b1;
    end else if (EN) begin
      nextO    = advanceVal;
      nextWrap = (advanceVal == homeVal);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      O     <= homeVal;
      WRAP  <= 1'b0;
      FAULT <= 1'b0;
    end else begin
      O     <= nextO;
      WRAP  <= nextWrap;
      FAULT <= nextFault;
    end
  end

endmodule

// File: tb/tb_ring_sequencer_n.sv
// Bench for ring_sequencer_n at WIDTH 4, 2 and 7 sharing one control stream; a phase-index
// model predicts every output each cycle, and directed literals pin the model.
module tb_ring_sequencer_n;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       DIR = 1'b0;
  logic       MODE = 1'b0;
  logic       LOAD = 1'b0;
  logic [3:0] lv4 = '0;
  logic [1:0] lv2 = '0;
  logic [6:0] lv7 = '0;
  logic [3:0] o4;
  logic [1:0] o2;
  logic [6:0] o7;
  logic       wrap4, wrap2, wrap7, fault4, fault2, fault7;

  int passCount = 0;
  int totalCount = 0;

  always #5 CLK = ~CLK;

  ring_sequencer_n #(.WIDTH(4)) u4 (.CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .MODE(MODE),
    .LOAD(LOAD), .LOAD_VAL(lv4), .O(o4), .WRAP(wrap4), .FAULT(fault4));
  ring_sequencer_n #(.WIDTH(2)) u2 (.CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .MODE(MODE),
    .LOAD(LOAD), .LOAD_VAL(lv2), .O(o2), .WRAP(wrap2), .FAULT(fault2));
  ring_sequencer_n #(.WIDTH(7)) u7 (.CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .MODE(MODE),
    .LOAD(LOAD), .LOAD_VAL(lv7), .O(o7), .WRAP(wrap7), .FAULT(fault7));

  // Model: a legal state is identified by its phase index k in the sequence; HOME is k=0.
  function automatic logic [7:0] pattern(input int w, input logic mode, input int k);
    int v;
    if (!mode) v = 1 << k;
    else if (k <= w) v = (1 << k) - 1;
    else v = ((1 << w) - 1) & ~((1 << (k - w)) - 1);
    return 8'(v);
  endfunction

  function automatic int phaseOf(input int w, input logic mode, input logic [7:0] vec);
    int per;
    per = mode ? 2 * w : w;
    for (int k = 0; k < per; k++)
      if (pattern(w, mode, k) == vec) return k;
    return -1;
  endfunction

  int         widths [3] = '{4, 2, 7};
  logic [7:0] mO [3];
  logic       mWrap [3];
  logic       mFault [3];
  logic       modelValid = 1'b0;

  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      int w, ph, per, np;
      logic [7:0] lv, mask;
      w    = widths[i];
      mask = 8'((1 << w) - 1);
      lv   = (i == 0) ? {4'b0, lv4} : (i == 1) ? {6'b0, lv2} : {1'b0, lv7};
      per  = MODE ? 2 * w : w;
      ph   = phaseOf(w, MODE, mO[i] & mask);
      if (RST || (!LOAD && ph < 0)) begin
        mO[i]     <= pattern(w, MODE, 0);
        mWrap[i]  <= 1'b0;
        mFault[i] <= !RST;
      end else if (LOAD) begin
        mO[i]     <= lv & mask;
        mWrap[i]  <= 1'b0;
        mFault[i] <= 1'b0;
      end else if (EN) begin
        np = DIR ? (ph + per - 1) % per : (ph + 1) % per;
        mO[i]     <= pattern(w, MODE, np);
        mWrap[i]  <= (np == 0);
        mFault[i] <= 1'b0;
      end else begin
        mWrap[i]  <= 1'b0;
        mFault[i] <= 1'b0;
      end
    end
    if (RST) modelValid <= 1'b1;
  end

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got O/WRAP/FAULT=%b want %b at %0t", nm, act, exp, $time);
  endtask

  always @(negedge CLK) begin
    if (modelValid) begin
      check("model_w4", {4'b0, o4, wrap4, fault4}, {mO[0], mWrap[0], mFault[0]});
      check("model_w2", {6'b0, o2, wrap2, fault2}, {mO[1], mWrap[1], mFault[1]});
      check("model_w7", {1'b0, o7, wrap7, fault7}, {mO[2], mWrap[2], mFault[2]});
    end
  end

  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic lit4(input string nm, input logic [3:0] o, input logic w, input logic f);
    check(nm, {4'b0, o4, wrap4, fault4}, {4'b0, o, w, f});
  endtask

  initial begin
    // reset and ring up
    cycle();
    lit4("reset_w4", 4'b0001, 1'b0, 1'b0);
    check("reset_w2", {6'b0, o2, wrap2, fault2}, {6'b0, 2'b01, 2'b00});
    RST = 1'b0; EN = 1'b1;
    cycle(); lit4("ring_up_1", 4'b0010, 1'b0, 1'b0);
    cycle(2); lit4("ring_up_3", 4'b1000, 1'b0, 1'b0);
    cycle(); lit4("ring_up_wrap", 4'b0001, 1'b1, 1'b0);
    check("ring_up_w7", {1'b0, o7, wrap7, fault7}, {8'b0010000, 2'b00});
    // ring down, then reverse at 0100
    DIR = 1'b1;
    cycle(); lit4("ring_dn_1", 4'b1000, 1'b0, 1'b0);
    cycle(); lit4("ring_dn_2", 4'b0100, 1'b0, 1'b0);
    DIR = 1'b0;
    cycle(); lit4("dir_flip", 4'b1000, 1'b0, 1'b0);
    // Johnson from reset
    RST = 1'b1; MODE = 1'b1;
    cycle(); lit4("johnson_home", 4'b0000, 1'b0, 1'b0);
    RST = 1'b0;
    cycle(4); lit4("johnson_4", 4'b1111, 1'b0, 1'b0);
    cycle(4); lit4("johnson_wrap", 4'b0000, 1'b1, 1'b0);
    check("johnson_w2", {6'b0, o2, wrap2, fault2}, {6'b0, 2'b00, 2'b10});
    check("johnson_w7", {1'b0, o7, wrap7, fault7}, {8'b1111110, 2'b00});
    // illegal load then correction with EN=0
    MODE = 1'b0; EN = 1'b0; LOAD = 1'b1; lv4 = 4'b0110;
    cycle(); lit4("load_illegal", 4'b0110, 1'b0, 1'b0);
    LOAD = 1'b0;
    cycle(); lit4("correct_fault", 4'b0001, 1'b0, 1'b1);
    cycle(); lit4("fault_one_cycle", 4'b0001, 1'b0, 1'b0);
    // mode changes
    EN = 1'b1;
    cycle(2); lit4("ring_at_0100", 4'b0100, 1'b0, 1'b0);
    MODE = 1'b1;
    cycle(); lit4("mode_illegal", 4'b0000, 1'b0, 1'b1);
    MODE = 1'b0;
    cycle(); lit4("ring_from_zero", 4'b0001, 1'b0, 1'b1);
    MODE = 1'b1;
    cycle(); lit4("mode_legal", 4'b0011, 1'b0, 1'b0);
    // hold, then reset beats load and enable
    EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(); lit4("hold", 4'b0011, 1'b0, 1'b0);
    end
    RST = 1'b1; LOAD = 1'b1; EN = 1'b1; lv4 = 4'b1010;
    cycle(); lit4("reset_wins", 4'b0000, 1'b0, 1'b0);
    RST = 1'b0; LOAD = 1'b0;
    // randomized phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      RST  = ($urandom_range(0, 63) == 0);
      LOAD = ($urandom_range(0, 15) == 0);
      EN   = ($urandom_range(0, 3) != 0);
      DIR  = ($urandom_range(0, 7) == 0) ? ~DIR : DIR;
      MODE = ($urandom_range(0, 15) == 0) ? ~MODE : MODE;
      lv4  = 4'($urandom);
      lv2  = 2'($urandom);
      lv7  = 7'($urandom);
      cycle();
    end
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
